// File: rtl/product_accum_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_accum_pkg;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF = 20;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus IN_W addend.
module sat_add #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned IN_W  = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - IN_W){addend[IN_W-1]}}, addend};
        // One guard bit is enough: disagreement with the old sign bit means out of range.
        sat  = wide[ACC_W] ^ wide[ACC_W-1];
        if (!sat) begin
            sum = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            sum            = '0;
            sum[ACC_W-1]   = 1'b1;
        end else begin
            sum            = '1;
            sum[ACC_W-1]   = 1'b0;
        end
    end

endmodule

// File: rtl/product_accum.sv
// Frame-based saturating accumulator of signed products with valid/ready result handshake.
module product_accum
    import product_accum_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_sat;
    logic               accept;

    sat_add #(
        .ACC_W (ACC_W),
        .IN_W  (IN_W)
    ) u_sat_add (
        .acc    (acc_q),
        .addend (in_data),
        .sum    (add_sum),
        .sat    (add_sat)
    );

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_sat;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accum.sv
// Randomized self-checking bench for product_accum against a frame-level dot-product model.
module tb_product_accum;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned CNT_W = 8;
    localparam longint      MAXV  = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint      MINV  = -(longint'(1) <<< (ACC_W - 1));
    localparam longint      CMAX  = (longint'(1) <<< CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int nvec = 0;
    int nerr = 0;
    int beats[$];

    product_accum #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Frame reference: running sum clamped after every term, count clamps at its maximum.
    task automatic model(output longint s, output longint c, output longint o);
        s = 0; c = 0; o = 0;
        foreach (beats[i]) begin
            if (i == 0) begin
                s = beats[i];
            end else begin
                s = s + beats[i];
                if (s > MAXV) begin s = MAXV; o = 1; end
                if (s < MINV) begin s = MINV; o = 1; end
            end
            c = (c < CMAX) ? c + 1 : CMAX;
        end
    endtask

    task automatic check_outputs(input string tag);
        longint es, ec, eo;
        model(es, ec, eo);
        check({tag, ".valid"}, longint'(out_valid), 1);
        check({tag, ".in_ready"}, longint'(in_ready), 0);
        check({tag, ".sum"}, longint'($signed(out_sum)), es);
        check({tag, ".count"}, longint'(out_count), ec);
        check({tag, ".ovf"}, longint'(out_ovf), eo);
    endtask

    // Drives the frame in beats[] starting at a negedge; returns at the negedge after the last accept.
    task automatic send_beats(input bit gaps, input bit with_last);
        foreach (beats[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            if (i == 0 || gaps) check("beat.in_ready", longint'(in_ready), 1);
            if (gaps) check("beat.no_early_valid", longint'(out_valid), 0);
            in_valid = 1'b1;
            in_data  = IN_W'(beats[i]);
            in_last  = with_last && (i == beats.size() - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        send_beats(gaps, 1'b1);
        check_outputs(tag);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        check("drain.valid_low", longint'(out_valid), 0);
        check("drain.in_ready", longint'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, longint'(in_ready), 1);
        check({tag, ".valid"}, longint'(out_valid), 0);
        check({tag, ".sum"}, longint'(out_sum), 0);
        check({tag, ".count"}, longint'(out_count), 0);
        check({tag, ".ovf"}, longint'(out_ovf), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        beats = '{100, -30, 7};
        run_frame("basic", 1'b0);
        drain();

        beats = '{-16384};
        run_frame("single", 1'b0);
        drain();

        beats.delete();
        repeat (32) beats.push_back(16384);
        run_frame("sat_pos", 1'b0);
        drain();

        beats.delete();
        repeat (33) beats.push_back(-16384);
        run_frame("sat_neg", 1'b0);
        drain();

        beats = '{5};
        run_frame("ovf_clear", 1'b0);
        drain();

        beats.delete();
        repeat (300) beats.push_back(0);
        run_frame("count_sat", 1'b0);
        drain();

        // Backpressure: result held while upstream keeps offering a beat.
        beats = '{3, 4};
        run_frame("stall", 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd999;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_outputs("stall_hold");
        end
        out_ready = 1'b1;
        in_data   = 16'd11;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake.valid_low", longint'(out_valid), 0);
        check("handshake.in_ready", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        beats = '{11};
        check_outputs("after_stall");
        drain();

        // Abort a frame with reset after two beats.
        beats = '{1000, -2000};
        send_beats(1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        beats = '{1, 2};
        run_frame("post_reset", 1'b0);
        drain();

        // Reset during HOLD also clears the result.
        beats = '{42};
        run_frame("pre_hold_reset", 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("hold_reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Random multiplier-fed dot products, some biased toward saturation.
        for (int f = 0; f < 80; f++) begin
            int len;
            bit big;
            len = $urandom_range(1, 45);
            big = ($urandom_range(0, 3) == 0);
            beats.delete();
            for (int k = 0; k < len; k++) begin
                int a, b;
                if (big) begin
                    a = $urandom_range(64, 127);
                    b = $urandom_range(64, 127);
                    if (f % 2 == 1) a = -a;
                end else begin
                    a = int'($signed(8'($urandom)));
                    b = int'($signed(8'($urandom)));
                end
                beats.push_back(a * b);
            end
            run_frame("mac", 1'b1);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_outputs("mac_wait");
                end
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
